// File: rtl/sbox_builder_pkg.sv
// sbox_builder_pkg: shared types and helpers
// for the chaotic S-box table builder.
package sbox_builder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [15:0] REJ_MAX = 16'hFFFF;

  function automatic int unsigned sym_depth(
    input int unsigned w
  );
    return 32'd1 << w;
  endfunction

endpackage

// File: rtl/sbox_seen_bitmap.sv
// sbox_seen_bitmap: one flag per symbol with
// a combinational hit for the tested index.
module sbox_seen_bitmap
  import sbox_builder_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] idx,
  input  logic         set,
  output logic         hit
);

  localparam int unsigned N = sym_depth(W);

  logic [N-1:0] bits;

  assign hit = bits[idx];

  // Flags clear as a block; a set marks one symbol seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bits <= '0;
    end else if (clear) begin
      bits <= '0;
    end else if (set) begin
      bits[idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/sbox_builder.sv
// sbox_builder: dedupes chaotic samples into a
// forward (and optional inverse) S-box table.
module sbox_builder
  import sbox_builder_pkg::*;
#(
  parameter int unsigned SYM_W    = 8,
  parameter int unsigned SAMPLE_W = 32,
  parameter int unsigned BIT_OFS  = 0,
  parameter bit          INV_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  input  logic [SYM_W-1:0]    lookup_addr,
  input  logic                lookup_inv,
  output logic [SYM_W-1:0]    lookup_data,
  output logic                busy,
  output logic                done,
  output logic [SYM_W:0]      fill_count,
  output logic [15:0]         reject_count
);

  localparam int unsigned DEPTH = sym_depth(SYM_W);
  localparam logic [SYM_W:0] ONE =
    (SYM_W+1)'(1);
  localparam logic [SYM_W:0] LAST =
    (SYM_W+1)'(DEPTH) - ONE;

  state_e           state;
  state_e           state_nxt;
  logic [SYM_W-1:0] sym;
  logic             hit;
  logic             fire;
  logic             uniq;
  logic             dup;
  logic             enter_clr;
  logic [SYM_W-1:0] wr_idx;
  logic [SYM_W-1:0] fwd_rd;
  logic [SYM_W-1:0] inv_rd;
  logic [SYM_W-1:0] rd_data;

  logic [SYM_W-1:0] fwd_mem [DEPTH];

  assign sym       = in_data[BIT_OFS +: SYM_W];
  assign in_ready  = (state == FILL);
  assign busy      = (state == CLEAR) ||
                     (state == FILL);
  assign done      = (state == DONE);
  assign fire      = in_valid & in_ready & ~start;
  assign uniq      = fire & ~hit;
  assign dup       = fire & hit;
  assign enter_clr = (state_nxt == CLEAR) &&
                     (state != CLEAR);
  assign wr_idx    = fill_count[SYM_W-1:0];

  sbox_seen_bitmap #(
    .W (SYM_W)
  ) u_seen (
    .clk   (clk),
    .rst   (rst),
    .clear (state == CLEAR),
    .idx   (sym),
    .set   (uniq),
    .hit   (hit)
  );

  // Build sequencing; start aborts any fill.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = FILL;
      FILL: begin
        if (start) begin
          state_nxt = CLEAR;
        end else if (uniq && fill_count == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE:    if (start) state_nxt = CLEAR;
      default: state_nxt = IDLE;
    endcase
  end

  // State and counters; counters zero on CLEAR entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      fill_count   <= '0;
      reject_count <= '0;
    end else begin
      state <= state_nxt;
      if (enter_clr) begin
        fill_count   <= '0;
        reject_count <= '0;
      end else begin
        if (uniq) fill_count <= fill_count + ONE;
        if (dup && reject_count != REJ_MAX) begin
          reject_count <= reject_count + 16'd1;
        end
      end
    end
  end

  // Forward table: fill order -> symbol.
  always_ff @(posedge clk) begin
    if (uniq) fwd_mem[wr_idx] <= sym;
  end

  assign fwd_rd = fwd_mem[lookup_addr];

  if (INV_EN) begin : g_inv
    logic [SYM_W-1:0] inv_mem [DEPTH];

    // Inverse table: symbol -> fill order.
    always_ff @(posedge clk) begin
      if (uniq) inv_mem[sym] <= wr_idx;
    end

    assign inv_rd = inv_mem[lookup_addr];
  end else begin : g_no_inv
    assign inv_rd = '0;
  end

  assign rd_data = (INV_EN && lookup_inv) ?
                   inv_rd : fwd_rd;

  // Registered lookup, forced to zero until built.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lookup_data <= '0;
    end else begin
      lookup_data <= done ? rd_data : '0;
    end
  end

endmodule

// File: doc/sbox_builder.md
Name: sbox_builder

Overview:
- Parametrised successor to the fixed 8-bit chaotic S-box path.
- Consumes a valid/ready stream of raw chaotic-map samples.
- Extracts a SYM_W-bit symbol from each sample at a configurable bit offset and discards duplicates with an internal seen-bitmap.
- Fills a 2^SYM_W forward table, plus an optional inverse table, then serves registered lookups. Sits after the mixer and replaces the separate seen/counter/checker/sbox chain.

Parameters:
- SYM_W, 8, symbol width; table depth DEPTH = 2^SYM_W.
- SAMPLE_W, 32, width of the incoming mixed sample.
- BIT_OFS, 0, LSB index of the extracted field; requires BIT_OFS+SYM_W <= SAMPLE_W.
- INV_EN, 1, 1 = build and serve the inverse table; 0 = inverse table removed.

Ports:
- clk, input, 1, clock; all state changes on rising edge.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse; begins or restarts a build.
- in_valid, input, 1, in_data holds a sample.
- in_data, input, SAMPLE_W, chaotic sample.
- in_ready, output, 1, block accepts a sample this cycle.
- lookup_addr, input, SYM_W, lookup index.
- lookup_inv, input, 1, 1 = read inverse table (ignored, treated as 0, when INV_EN=0).
- lookup_data, output, SYM_W, registered lookup result.
- busy, output, 1, build in progress.
- done, output, 1, table complete and valid.
- fill_count, output, SYM_W+1, unique symbols written so far (0..DEPTH).
- reject_count, output, 16, duplicates dropped in the current build; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; in_ready, busy, done = 0.
  - fill_count, reject_count, lookup_data = 0.
  - Seen-bitmap cleared. Table RAM contents not reset.
- States:
  - IDLE -> CLEAR on start.
  - CLEAR, 1 cycle: bitmap cleared, fill_count=0, reject_count=0, done=0, busy=1. Then -> FILL.
  - FILL: in_ready=1.
  - FILL -> DONE when the DEPTH-th unique symbol is written.
  - DONE: done=1, busy=0, in_ready=0. DONE -> CLEAR on start.
- start during FILL: abort the build and go to CLEAR next cycle. A handshake in that same cycle is ignored.
- start in CLEAR: ignored.
- Symbol extraction: sym = in_data[BIT_OFS +: SYM_W].
- On each accepted handshake (in_valid & in_ready):
  - Bitmap[sym]=0 (unique): fwd[fill_count]=sym; inv[sym]=fill_count[SYM_W-1:0] (if INV_EN); bitmap[sym]=1; fill_count+1.
  - Bitmap[sym]=1 (duplicate): no table write; reject_count+1, saturating.
  - Latency: both the decision and the write complete in the handshake cycle. A sample in the next cycle sees the updated bitmap, so back-to-back identical symbols must be rejected.
- Completion: the handshake that makes fill_count=DEPTH moves the FSM to DONE on the same edge. in_ready is 0 from the next cycle, so no sample beyond the DEPTH-th is ever accepted.
- Lookup:
  - When done=1, lookup_data <= (lookup_inv ? inv[lookup_addr] : fwd[lookup_addr]) every cycle, 1-cycle latency.
  - When done=0, lookup_data <= 0.
- Bijection: after DONE, fwd is a permutation of 0..DEPTH-1 and inv[fwd[i]]=i for all i.
- Reset mid-FILL: returns to IDLE with done=0; the next build starts with a fresh bitmap.
- in_valid without in_ready: no effect, no count change.
- DEPTH=2^SYM_W is computed using widths sized SYM_W+1; SYM_W range is 2..10.

Decomposition:
- Package sbox_builder_pkg:
  - state enum {IDLE, CLEAR, FILL, DONE}.
  - Function computing DEPTH from SYM_W.
  - Localparam REJ_MAX = 16'hFFFF.
- Sub-module sbox_seen_bitmap, holding the DEPTH-bit register:
  - Inputs: clear, test/set index, set strobe.
  - Output: combinational hit for the index being tested.
  - Reused by future key-schedule dedupe.
- Tables are inferred memories in the top module.

Test Plan:
- SYM_W=4, BIT_OFS=0: reset, start, feed samples 0..15 in order -> fill_count=16, done=1 one cycle after the 16th handshake, reject_count=0, fwd[i]=i, inv[i]=i.
- SYM_W=4: feed 3,3,3,7 back-to-back -> only the first 3 and the 7 written, reject_count=2, fill_count=2.
- SYM_W=4, BIT_OFS=8: sample 32'h0000_0A00 -> sym=10 written at fwd[0]. Sample 32'h0000_00FA -> sym=0.
- Permutation feed 15,14,...,0, then lookup_addr=2, lookup_inv=1 -> lookup_data=13 one cycle later. lookup_inv=0, addr=2 -> 13.
- Start asserted after 5 unique symbols -> CLEAR, fill_count=0, reject_count=0, done=0. Previously seen symbols are accepted again.
- rst low mid-FILL (8 symbols written) -> immediately busy=0, in_ready=0, fill_count=0. Hold in_valid=1 in DONE -> in_ready=0, counters unchanged.
